// File: rtl/imm_gen_stage_pkg.sv
// Shared types for the immediate-generation stage: immediate formats, RV32I opcodes,
// and the decode result carried through the skid buffer.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_CSR  = 3'd6
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [31:0] imm;
    imm_type_e   imm_type;
    logic        illegal;
  } imm_result_t;

  typedef struct packed {
    imm_result_t res;
    logic [31:0] instr;
    logic [31:0] pc;
  } stage_entry_t;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus of the immediate-generation stage, including the flush request.
// slave = the stage itself, master = whoever drives instructions and consumes results.
interface imm_gen_stage_if;
  import imm_pkg::*;

  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  imm_type_e   out_type;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_instr, out_pc, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_instr, out_pc, out_illegal
  );

endinterface

// File: rtl/imm_gen_stage_extract.sv
// Combinational RV32I immediate decoder. With IMM_SIGN_EXTEND_EN defined, I/S/B/J
// immediates are sign-extended from instr[31]; otherwise they are zero-extended.
module imm_extract
  import imm_pkg::*;
(
  input  logic [31:0] instr,
  output imm_result_t result
);

  logic [6:0] opcode;
  logic       fill;

  assign opcode = instr[6:0];

`ifdef IMM_SIGN_EXTEND_EN
  assign fill = instr[31];
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    result = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        result.imm_type = IMM_I;
        result.imm      = {{20{fill}}, instr[31:20]};
      end
      OP_STORE: begin
        result.imm_type = IMM_S;
        result.imm      = {{20{fill}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        result.imm_type = IMM_B;
        result.imm      = {{19{fill}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        result.imm_type = IMM_U;
        result.imm      = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        result.imm_type = IMM_J;
        result.imm      = {{11{fill}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      // Only the immediate forms of CSR ops (funct3[2]=1) carry a zimm field.
      OP_SYSTEM: begin
        if (instr[14]) begin
          result.imm_type = IMM_CSR;
          result.imm      = {27'b0, instr[19:15]};
        end
      end
      OP_REG: begin
        result.imm_type = IMM_NONE;
      end
      default: begin
        result.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode, then a 2-entry skid buffer (output + skid).
// Build option: IMM_SIGN_EXTEND_EN selects sign extension of I/S/B/J immediates.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  imm_gen_stage_if.slave bus
);

  imm_result_t  decoded;
  stage_entry_t in_entry;
  stage_entry_t out_q;
  stage_entry_t skid_q;
  logic         out_valid_q;
  logic         skid_valid_q;
  logic         in_fire;
  logic         out_free;

  imm_extract u_extract (
    .instr  (bus.in_instr),
    .result (decoded)
  );

  assign in_entry.res   = decoded;
  assign in_entry.instr = bus.in_instr[XLEN-1:0];
  assign in_entry.pc    = bus.in_pc[XLEN-1:0];

  assign in_fire  = bus.in_valid & ~skid_valid_q;
  assign out_free = ~out_valid_q | bus.out_ready;

  // The skid entry always drains first, and in_ready is low while it is full,
  // so a new input never competes with it for the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= in_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready    = ~skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_q.res.imm;
  assign bus.out_type    = out_q.res.imm_type;
  assign bus.out_illegal = out_q.res.illegal;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_pc      = out_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed format/handshake cases, then random
// traffic checked against a queue-based reference of the stage's buffered contents.
module tb_imm_gen_stage;

`ifdef IMM_SIGN_EXTEND_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  typedef struct {
    logic [31:0] imm;
    logic [31:0] typ;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t model_q[$];

  imm_gen_stage_if bus ();

  imm_gen_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference decode built from the field definitions with shifts and masks.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] op;
    op = ins & 32'h7F;
    e.imm = 32'h0; e.typ = 32'd0; e.ill = 1'b0; e.instr = ins; e.pc = pc;
    case (op)
      32'h03, 32'h13, 32'h67: begin
        e.typ = 1; e.imm = ins >> 20;
        if (SEXT && ins[31]) e.imm = e.imm | 32'hFFFFF000;
      end
      32'h23: begin
        e.typ = 2; e.imm = ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
        if (SEXT && ins[31]) e.imm = e.imm | 32'hFFFFF000;
      end
      32'h63: begin
        e.typ = 3;
        e.imm = (((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
              | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
        if (SEXT && ins[31]) e.imm = e.imm | 32'hFFFFE000;
      end
      32'h37, 32'h17: begin
        e.typ = 4; e.imm = ins & 32'hFFFFF000;
      end
      32'h6F: begin
        e.typ = 5;
        e.imm = (((ins >> 31) & 1) << 20) | (((ins >> 12) & 32'hFF) << 12)
              | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
        if (SEXT && ins[31]) e.imm = e.imm | 32'hFFE00000;
      end
      32'h73: begin
        if (ins[14]) begin e.typ = 6; e.imm = (ins >> 15) & 32'h1F; end
      end
      32'h33: e.typ = 0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, check registered outputs, advance the model.
  task automatic apply_stimulus(input bit r, input bit f, input bit iv,
                                input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
    bit exp_ready;
    bit exp_valid;
    rst           = r;
    bus.flush     = f;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    exp_ready = (model_q.size() < 2);
    exp_valid = (model_q.size() > 0);
    check_output("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
    check_output("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    if (exp_valid && bus.out_valid === 1'b1) begin
      check_output("out_imm", bus.out_imm, model_q[0].imm);
      check_output("out_type", {29'b0, bus.out_type}, model_q[0].typ);
      check_output("out_illegal", {31'b0, bus.out_illegal}, {31'b0, model_q[0].ill});
      check_output("out_instr", bus.out_instr, model_q[0].instr);
      check_output("out_pc", bus.out_pc, model_q[0].pc);
    end
    if (r || f) begin
      model_q.delete();
    end else begin
      if (exp_valid && ordy) void'(model_q.pop_front());
      if (iv && exp_ready) model_q.push_back(ref_decode(ins, pc));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] ops [10];
    logic [31:0] ins;
    ops = '{32'h03, 32'h13, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F, 32'h73, 32'h33};
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check_output("rst_out_imm", bus.out_imm, 32'h0);
    check_output("rst_out_type", {29'b0, bus.out_type}, 32'd0);
    check_output("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
    check_output("rst_out_instr", bus.out_instr, 32'h0);
    check_output("rst_out_pc", bus.out_pc, 32'h0);

    // Directed immediates with known results.
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFF00093, 32'h1000, 1'b1);
    check_output("addi_imm", bus.out_imm, SEXT ? 32'hFFFFFFFF : 32'h00000FFF);
    check_output("addi_type", {29'b0, bus.out_type}, 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFE000EE3, 32'h1004, 1'b1);
    check_output("beq_imm", bus.out_imm, SEXT ? 32'hFFFFFFFC : 32'h00001FFC);
    check_output("beq_type", {29'b0, bus.out_type}, 32'd3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h123450B7, 32'h1008, 1'b1);
    check_output("lui_imm", bus.out_imm, 32'h12345000);
    check_output("lui_type", {29'b0, bus.out_type}, 32'd4);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h300FD073, 32'h100C, 1'b1);
    check_output("csrrwi_imm", bus.out_imm, 32'h0000001F);
    check_output("csrrwi_type", {29'b0, bus.out_type}, 32'd6);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000007F, 32'h1010, 1'b1);
    check_output("illegal_flag", {31'b0, bus.out_illegal}, 32'd1);
    check_output("illegal_imm", bus.out_imm, 32'h0);
    idle(2);

    // Backpressure: third input must be refused, then the first two drain in order.
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00100093, 32'h2000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00200093, 32'h2004, 1'b0);
    check_output("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00300093, 32'h2008, 1'b0);
    check_output("bp_first_pc", bus.out_pc, 32'h2000);
    idle(3);

    // Flush with both entries full, input in the flush cycle dropped.
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00400093, 32'h3000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00500093, 32'h3004, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h00600093, 32'h3008, 1'b0);
    check_output("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_output("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00700093, 32'h300C, 1'b1);
    check_output("post_flush_pc", bus.out_pc, 32'h300C);
    idle(2);

    // Reset with both entries full, also overriding a flush.
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0080006F, 32'h4000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00900023, 32'h4004, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h00A00093, 32'h4008, 1'b1);
    check_output("rst_full_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check_output("rst_full_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check_output("rst_full_out_pc", bus.out_pc, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h00B00093, 32'h400C, 1'b1);
    check_output("post_rst_pc", bus.out_pc, 32'h400C);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) ins = $urandom();
      else ins = ($urandom() & 32'hFFFFFF80) | ops[$urandom_range(9)];
      apply_stimulus($urandom_range(99) == 0, $urandom_range(39) == 0,
                     $urandom_range(3) != 0, ins, $urandom(), $urandom_range(2) != 0);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
